// File: rtl/ace_req_gen_if.sv
// rtl/ace_req_gen_if.sv - ACE read/write channel bundle between ace_req_gen and the interconnect
interface ace_req_gen_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arsnoop;

   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [3:0]        rresp;
   logic              rack;

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awsnoop;

   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;

   logic              bvalid;
   logic              bready;
   logic              wack;

   modport master (
      output arvalid, araddr, arsnoop,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready, rack,
      output awvalid, awaddr, awsnoop,
      input  awready,
      output wvalid, wdata,
      input  wready,
      input  bvalid,
      output bready, wack
   );

   modport slave (
      input  arvalid, araddr, arsnoop,
      output arready,
      output rvalid, rdata, rresp,
      input  rready, rack,
      input  awvalid, awaddr, awsnoop,
      output awready,
      input  wvalid, wdata,
      output wready,
      output bvalid,
      input  bready, wack
   );
endinterface

// File: rtl/ace_req_gen.sv
// rtl/ace_req_gen.sv - ACE request generator turning cache miss/upgrade/writeback commands into ACE transactions
// Define ACE_REQ_TIMEOUT_EN to add the 8-bit stall watchdog that aborts to IDLE and pulses ace_err.
module ace_req_gen #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read_req,
   input  logic              write_req,
   input  logic              invalid_req,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ace_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_shared,
   output logic              resp_dirty,
   output logic              busy,
   output logic              ace_err,
   ace_req_gen_if.master     ace
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_RACK = 3'd3;
   localparam logic [2:0] S_AW_W = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_WACK = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   localparam logic [3:0] SNOOP_READ_SHARED = 4'b0001;
   localparam logic [3:0] SNOOP_READ_UNIQUE = 4'b0111;
   localparam logic [3:0] SNOOP_CLEAN_UNIQUE = 4'b1011;
   localparam logic [2:0] SNOOP_WRITE_BACK = 3'b011;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [3:0]        snoop_q;
   logic [3:0]        snoop_sel;
   logic              any_req;
   logic              aw_done;
   logic              w_done;
   logic              aw_hs;
   logic              w_hs;
   logic              aw_fin;
   logic              w_fin;
   logic              timeout;
   logic              unused_rresp;

   assign any_req = read_req | write_req | invalid_req | wb_req;

   assign ace.arvalid = (state == S_AR);
   assign ace.araddr  = addr_q;
   assign ace.arsnoop = snoop_q;
   assign ace.rready  = (state == S_R);
   assign ace.rack    = (state == S_RACK);
   assign ace.awvalid = (state == S_AW_W) && !aw_done;
   assign ace.awaddr  = addr_q;
   assign ace.awsnoop = SNOOP_WRITE_BACK;
   assign ace.wvalid  = (state == S_AW_W) && !w_done;
   assign ace.wdata   = data_q;
   assign ace.bready  = (state == S_B);
   assign ace.wack    = (state == S_WACK);

   assign ace_ready = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign ace_err   = timeout;

   // Only the shared/dirty bits of the R response are of interest here.
   assign unused_rresp = ^ace.rresp[1:0];

   // AW and W complete independently; a handshake this cycle counts as done.
   assign aw_hs  = ace.awvalid && ace.awready;
   assign w_hs   = ace.wvalid && ace.wready;
   assign aw_fin = aw_done || aw_hs;
   assign w_fin  = w_done || w_hs;

   always_comb begin
      snoop_sel = SNOOP_READ_SHARED;
      if (invalid_req) begin
         snoop_sel = SNOOP_CLEAN_UNIQUE;
      end else if (write_req) begin
         snoop_sel = SNOOP_READ_UNIQUE;
      end
   end

`ifdef ACE_REQ_TIMEOUT_EN
   logic [7:0] wd_cnt;
   logic       timed;

   assign timed   = (state == S_AR) || (state == S_R) || (state == S_AW_W) || (state == S_B);
   assign timeout = timed && (wd_cnt == 8'hFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= 8'd0;
      end else if (state_nxt != state) begin
         wd_cnt <= 8'd0;
      end else if (timed) begin
         wd_cnt <= wd_cnt + 8'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (wb_req) begin
               state_nxt = S_AW_W;
            end else if (any_req) begin
               state_nxt = S_AR;
            end
         end
         S_AR:   if (ace.arready) state_nxt = S_R;
         S_R:    if (ace.rvalid) state_nxt = S_RACK;
         S_RACK: state_nxt = S_DONE;
         S_AW_W: if (aw_fin && w_fin) state_nxt = S_B;
         S_B:    if (ace.bvalid) state_nxt = S_WACK;
         S_WACK: state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (timeout) begin
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         snoop_q     <= 4'd0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         resp_data   <= '0;
         resp_shared <= 1'b0;
         resp_dirty  <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && any_req) begin
            addr_q  <= req_addr;
            data_q  <= wb_data;
            snoop_q <= snoop_sel;
         end
         if (state == S_AW_W) begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if ((state == S_R) && ace.rvalid) begin
            resp_data   <= ace.rdata;
            resp_shared <= ace.rresp[3];
            resp_dirty  <= ace.rresp[2];
         end
      end
   end
endmodule
